// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t        : FSM encoding (IDLE, RD_WAIT, RESP), also used on the
//                    debug state output.
//   MMIO_*         : byte offsets (addr[7:0]) of the MMIO register bank.
//   *_BASE_NIB_DEF : default addr[31:28] region selectors.
//   merge_lanes    : byte-lane masked merge shared by RAM-style writes.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  localparam logic [7:0] MMIO_CYCLE   = 8'h10;
  localparam logic [7:0] MMIO_REQCNT  = 8'h14;
  localparam logic [7:0] MMIO_SCRATCH = 8'h18;

  localparam logic [3:0] MEM_BASE_NIB_DEF  = 4'h1;
  localparam logic [3:0] MMIO_BASE_NIB_DEF = 4'h8;

  // Lane i of the result comes from new_word when wen[i] is set, otherwise
  // from old_word. Any mask pattern is legal, contiguous or not.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the core-side decoder (master) and the memory
// responder (slave).
//   req_valid/req_ready : request handshake; req_addr, req_wen, req_wdata
//                         are the request payload.
//   resp_valid/resp_ready : response handshake; resp_rdata, resp_err are
//                           the response payload.
//
// Handshake rule for both channels: a transfer happens at the rising clock
// edge where valid and ready are both 1. The producer holds valid and the
// payload stable until that edge; ready may be high before valid arrives.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_wen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_bytemask_ram.sv
// Word-organised data RAM with per-byte-lane write enables and a registered
// (synchronous) read port, written in the template block-RAM inference
// expects.
//   clk   : rising-edge clock
//   en    : port enable; read and write happen only when set
//   we    : byte-lane write mask (bit i covers wdata[8i+7:8i])
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : word at addr, registered at the enabled edge (read-before-write)
module bytemask_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store path. Accepts one
// lane-encoded request at a time, performs byte-masked writes into the data
// RAM or the MMIO bank, and returns raw 32-bit read words.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : dmem_responder_if.slave (request and response channels)
//   dbg_state : current FSM state, for observation only
//
// Latency from acceptance edge N to resp_valid: RAM read 2 cycles, all other
// accesses (RAM write, MMIO, error) 1 cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int         DEPTH_WORDS   = 4096,
  parameter logic [3:0] MEM_BASE_NIB  = MEM_BASE_NIB_DEF,
  parameter logic [3:0] MMIO_BASE_NIB = MMIO_BASE_NIB_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_responder_if.slave        bus,
  output state_t                 dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] cycle_cnt;
  logic [31:0] req_cnt;
  logic [31:0] scratch;

  // ---------------------------------------------------------------------
  // Decode of the request presented in IDLE. Everything needed later is
  // captured at the acceptance edge, so the inputs may change afterwards.
  // ---------------------------------------------------------------------
  logic          accept;
  logic          is_write;
  logic          ram_hit;
  logic          mmio_hit;
  logic [7:0]    mmio_off;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_addr_bits;

  assign accept   = req_ready_q && bus.req_valid;
  assign is_write = |bus.req_wen;
  assign mmio_off = bus.req_addr[7:0];

  // The word index is widened to 32 bits so the range check works for any
  // power-of-two depth.
  assign ram_hit  = (bus.req_addr[31:28] == MEM_BASE_NIB) &&
                    ({6'd0, bus.req_addr[27:2]} < 32'(DEPTH_WORDS));
  assign mmio_hit = (bus.req_addr[31:28] == MMIO_BASE_NIB) &&
                    ((mmio_off == MMIO_CYCLE) || (mmio_off == MMIO_REQCNT) ||
                     (mmio_off == MMIO_SCRATCH));

  // The RAM is driven straight from the request so the write commits and
  // the synchronous read is issued on the acceptance edge itself.
  assign ram_we   = (accept && ram_hit) ? bus.req_wen : 4'b0000;
  assign ram_addr = bus.req_addr[AW+1:2];

  assign unused_addr_bits = ^bus.req_addr[1:0];

  bytemask_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (accept && ram_hit),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // FSM, MMIO registers and counters.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      cycle_cnt    <= 32'd0;
      req_cnt      <= 32'd0;
      scratch      <= 32'd0;
    end else begin
      // Free-running; a write to the CYCLE register below overrides this.
      cycle_cnt <= cycle_cnt + 32'd1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_cnt     <= req_cnt + 32'd1;
            req_ready_q <= 1'b0;
            if (ram_hit) begin
              if (is_write) begin
                state        <= ST_RESP;
                resp_valid_q <= 1'b1;
                resp_rdata_q <= 32'd0;
                resp_err_q   <= 1'b0;
              end else begin
                state <= ST_RD_WAIT;
              end
            end else if (mmio_hit) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'd0;
              case (mmio_off)
                MMIO_CYCLE: begin
                  if (is_write) cycle_cnt    <= 32'd0;
                  else          resp_rdata_q <= cycle_cnt;
                end
                // Read-only; writes complete without error. The value
                // returned excludes this request's own increment.
                MMIO_REQCNT: begin
                  if (!is_write) resp_rdata_q <= req_cnt;
                end
                MMIO_SCRATCH: begin
                  if (is_write) scratch      <= merge_lanes(scratch, bus.req_wdata, bus.req_wen);
                  else          resp_rdata_q <= scratch;
                end
                default: ;
              endcase
            end else begin
              // Unmapped or out of range: nothing is modified.
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'd0;
              resp_err_q   <= 1'b1;
            end
          end
        end

        ST_RD_WAIT: begin
          // RAM output holds since its port is only enabled on acceptance.
          state        <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ram_rdata;
          resp_err_q   <= 1'b0;
        end

        ST_RESP: begin
          // Payload registers are left untouched here, so they stay stable
          // for as long as the core stalls.
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end

        default: begin
          state        <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state;

endmodule
